// File: rtl/riscv_ctrl_pkg.sv
// Shared state codes, opcodes and select encodings
// for the multi-cycle RV32I control path.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       adr_src;
        logic       fetch;
        logic       pc_jump;
        logic       branch;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_state_decoder.sv
// Pure state -> control decode; the top qualifies
// the fetch/branch terms with mem_ready and zero.
module mc_state_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [6:0] op,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic       fetch,
    output logic       pc_jump,
    output logic       branch,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       illegal
);

    ctrl_t c;

    always_comb begin
        c = '0;
        case (state)
            S_FETCH: begin
                c.mem_read   = 1'b1;
                c.fetch      = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALU_ADD;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_B;
                c.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                c.imm_src   = (op == OP_SW) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                c.mem_read   = 1'b1;
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_write  = 1'b1;
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALU_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_I;
                c.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALU_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_jump    = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_REG;
                c.alu_src_b  = SRCB_REG;
                c.alu_op     = ALU_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            S_TRAP: begin
                c.illegal = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
    end

    assign mem_read   = c.mem_read;
    assign mem_write  = c.mem_write;
    assign adr_src    = c.adr_src;
    assign fetch      = c.fetch;
    assign pc_jump    = c.pc_jump;
    assign branch     = c.branch;
    assign reg_write  = c.reg_write;
    assign result_src = c.result_src;
    assign alu_src_a  = c.alu_src_a;
    assign alu_src_b  = c.alu_src_b;
    assign alu_op     = c.alu_op;
    assign imm_src    = c.imm_src;
    assign illegal    = c.illegal;

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: state register,
// sequencing, handshake gating and retire counter.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_src,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_o
);

    state_t state;
    state_t next_state;
    logic   retire;

    logic d_mem_read;
    logic d_mem_write;
    logic d_fetch;
    logic d_pc_jump;
    logic d_branch;
    logic d_reg_write;

    mc_state_decoder u_dec (
        .state      (state),
        .op         (op),
        .mem_read   (d_mem_read),
        .mem_write  (d_mem_write),
        .adr_src    (adr_src),
        .fetch      (d_fetch),
        .pc_jump    (d_pc_jump),
        .branch     (d_branch),
        .reg_write  (d_reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .illegal    (illegal)
    );

    always_comb begin
        next_state = S_TRAP;
        case (state)
            S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECUTER;
                    OP_I:         next_state = S_EXECUTEI;
                    OP_JAL:       next_state = S_JAL;
                    OP_BEQ:       next_state = S_BEQ;
                    default:      next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            S_BEQ:      next_state = S_FETCH;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_TRAP;
        endcase
    end

    assign retire = (state == S_MEMWB)
                  | ((state == S_MEMWRITE) & mem_ready)
                  | (state == S_ALUWB)
                  | (state == S_BEQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= next_state;
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    // Reset parks the FSM in FETCH; its strobes must stay quiet until release.
    assign mem_read  = rst_n & d_mem_read;
    assign mem_write = rst_n & d_mem_write;
    assign reg_write = rst_n & d_reg_write;
    assign ir_write  = rst_n & d_fetch & mem_ready;
    assign pc_write  = rst_n & ((d_fetch & mem_ready)
                              | d_pc_jump
                              | (d_branch & zero));
    assign state_o   = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one
// task per scenario with hand-computed sequences.
module tb_multicycle_controller;

    logic        clk;
    logic        rst_n;
    logic [6:0]  op;
    logic        zero;
    logic        mem_ready;
    logic        mem_read;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  imm_src;
    logic        illegal;
    logic [31:0] instret;
    logic [3:0]  state_o;

    int checks;
    int errors;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .illegal    (illegal),
        .instret    (instret),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_dut();
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int exp_s[5] = '{0, 1, 6, 7, 0};
        op        = 7'b0110011;
        mem_ready = 1'b1;
        zero      = 1'b0;
        rst_n     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({mem_read, mem_write, ir_write, pc_write, reg_write} !== 5'b0
                || state_o !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold: en=%b state=%0d want en=00000 state=0",
                         {mem_read, mem_write, ir_write, pc_write, reg_write},
                         state_o);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (state_o !== 4'(exp_s[i])) begin
                errors++;
                $display("FAIL reset_seq[%0d]: state=%0d want %0d",
                         i, state_o, exp_s[i]);
            end
            checks++;
            if (reg_write !== (exp_s[i] == 7)) begin
                errors++;
                $display("FAIL reset_regwr[%0d]: reg_write=%b want %b",
                         i, reg_write, exp_s[i] == 7);
            end
        end
        checks++;
        if (instret !== 32'd1) begin
            errors++;
            $display("FAIL reset_instret: got %0d want 1", instret);
        end
    endtask

    task automatic test_load_stall();
        int   exp_s[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
        logic mr[8]    = '{1, 1, 1, 0, 0, 1, 1, 1};
        reset_dut();
        op = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            mem_ready = mr[i];
            #1;
            checks++;
            if (state_o !== 4'(exp_s[i])) begin
                errors++;
                $display("FAIL load_seq[%0d]: state=%0d want %0d",
                         i, state_o, exp_s[i]);
            end
            if (exp_s[i] == 3) begin
                checks++;
                if (mem_read !== 1'b1 || adr_src !== 1'b1) begin
                    errors++;
                    $display("FAIL load_memread[%0d]: rd=%b adr=%b want 1 1",
                             i, mem_read, adr_src);
                end
            end
            if (exp_s[i] == 4) begin
                checks++;
                if (result_src !== 2'b01 || reg_write !== 1'b1) begin
                    errors++;
                    $display("FAIL load_wb: res=%b wr=%b want 01 1",
                             result_src, reg_write);
                end
            end
        end
        mem_ready = 1'b1;
        checks++;
        if (instret !== 32'd1) begin
            errors++;
            $display("FAIL load_instret: got %0d want 1", instret);
        end
    endtask

    task automatic test_store();
        int exp_s[5] = '{0, 1, 2, 5, 0};
        int wr_cnt   = 0;
        int rw_cnt   = 0;
        reset_dut();
        op = 7'b0100011;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (mem_write === 1'b1) wr_cnt++;
            if (reg_write === 1'b1) rw_cnt++;
            checks++;
            if (state_o !== 4'(exp_s[i])) begin
                errors++;
                $display("FAIL store_seq[%0d]: state=%0d want %0d",
                         i, state_o, exp_s[i]);
            end
            if (exp_s[i] == 2) begin
                checks++;
                if (imm_src !== 2'b01) begin
                    errors++;
                    $display("FAIL store_imm: imm_src=%b want 01", imm_src);
                end
            end
        end
        checks++;
        if (wr_cnt !== 1 || rw_cnt !== 0) begin
            errors++;
            $display("FAIL store_strobes: mem_write cycles=%0d reg_write cycles=%0d want 1 0",
                     wr_cnt, rw_cnt);
        end
        checks++;
        if (instret !== 32'd1) begin
            errors++;
            $display("FAIL store_instret: got %0d want 1", instret);
        end
    endtask

    task automatic test_branch();
        int   exp_s[7] = '{0, 1, 10, 0, 1, 10, 0};
        logic zv[7]    = '{1, 1, 1, 0, 0, 0, 0};
        reset_dut();
        op = 7'b1100011;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            zero = zv[i];
            #1;
            checks++;
            if (state_o !== 4'(exp_s[i])) begin
                errors++;
                $display("FAIL branch_seq[%0d]: state=%0d want %0d",
                         i, state_o, exp_s[i]);
            end
            if (exp_s[i] == 10) begin
                checks++;
                if (pc_write !== zv[i] || alu_op !== 2'b01) begin
                    errors++;
                    $display("FAIL branch_beq[%0d]: pc_write=%b alu_op=%b want %b 01",
                             i, pc_write, alu_op, zv[i]);
                end
            end
        end
        zero = 1'b0;
        checks++;
        if (instret !== 32'd2) begin
            errors++;
            $display("FAIL branch_instret: got %0d want 2", instret);
        end
    endtask

    task automatic test_jal();
        int exp_s[5] = '{0, 1, 9, 7, 0};
        reset_dut();
        op = 7'b1101111;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (state_o !== 4'(exp_s[i])) begin
                errors++;
                $display("FAIL jal_seq[%0d]: state=%0d want %0d",
                         i, state_o, exp_s[i]);
            end
            if (exp_s[i] == 9) begin
                checks++;
                if (pc_write !== 1'b1 || alu_src_b !== 2'b10
                    || reg_write !== 1'b0) begin
                    errors++;
                    $display("FAIL jal_state: pc=%b srcb=%b rw=%b want 1 10 0",
                             pc_write, alu_src_b, reg_write);
                end
            end
            if (exp_s[i] == 7) begin
                checks++;
                if (reg_write !== 1'b1 || pc_write !== 1'b0) begin
                    errors++;
                    $display("FAIL jal_wb: rw=%b pc=%b want 1 0",
                             reg_write, pc_write);
                end
            end
        end
        checks++;
        if (instret !== 32'd1) begin
            errors++;
            $display("FAIL jal_instret: got %0d want 1", instret);
        end
    endtask

    task automatic test_illegal_reset();
        int exp_s[6] = '{0, 1, 11, 11, 11, 11};
        reset_dut();
        op = 7'b1111111;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (state_o !== 4'(exp_s[i])) begin
                errors++;
                $display("FAIL trap_seq[%0d]: state=%0d want %0d",
                         i, state_o, exp_s[i]);
            end
            if (exp_s[i] == 11) begin
                checks++;
                if (illegal !== 1'b1
                    || {mem_read, mem_write, ir_write, pc_write, reg_write} !== 5'b0) begin
                    errors++;
                    $display("FAIL trap_out[%0d]: illegal=%b en=%b want 1 00000",
                             i, illegal,
                             {mem_read, mem_write, ir_write, pc_write, reg_write});
                end
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (illegal !== 1'b0 || state_o !== 4'd0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL trap_reset: illegal=%b state=%0d instret=%0d want 0 0 0",
                     illegal, state_o, instret);
        end
        checks++;
        if ({mem_read, mem_write, ir_write, pc_write, reg_write} !== 5'b0) begin
            errors++;
            $display("FAIL trap_reset_en: en=%b want 00000",
                     {mem_read, mem_write, ir_write, pc_write, reg_write});
        end
        @(negedge clk);
        rst_n = 1'b1;
        op    = 7'b0110011;
        #1;
        checks++;
        if (state_o !== 4'd0 || ir_write !== 1'b1) begin
            errors++;
            $display("FAIL trap_release: state=%0d ir_write=%b want 0 1",
                     state_o, ir_write);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        op        = 7'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        test_reset();
        test_load_stall();
        test_store();
        test_branch();
        test_jal();
        test_illegal_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
